stream_fifo_buf: RTL

STREAM_FIFO_BUF -- requirements
Module: stream_fifo_buf

---
 rtl/stream_pkg.sv | 15 +
 rtl/stream_fifo_mem.sv | 33 +++
 rtl/stream_fifo_buf.sv | 110 +++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// stream_pkg: shared definitions for the stream FIFO buffer.
//   DATA_WIDTH_DEF : default payload width (24-bit packed RGB + sop + eop)
//   SOP_BIT/EOP_BIT: flag positions inside the payload (the buffer only carries them)
//   level_w()      : width needed to hold a fill level of 0..depth
package stream_pkg;

  localparam int DATA_WIDTH_DEF = 26;
  localparam int SOP_BIT        = 24;
  localparam int EOP_BIT        = 25;

  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// stream_fifo_mem: DEPTH x DATA_WIDTH register array, one synchronous write
// port and one asynchronous read port. Contents are not reset.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write payload
//   rd_addr : read address
//   rd_data : combinational read data at rd_addr
module stream_fifo_mem
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/stream_fifo_buf.sv
// stream_fifo_buf: valid/ready stream buffer, ready latency 0 on both sides.
//   clk, rst_n            : clock, synchronous active-low reset
//   flush                 : discard all stored beats (beat offered this cycle is dropped)
//   valid_in/data_in      : upstream beat, ready_out = ~full & ~flush
//   valid_out/data_out    : downstream beat (data_out is zero when not valid)
//   ready_in              : downstream accept
//   level, almost_full    : fill level and level >= AFULL_LEVEL, from registered state
// Optional macro STREAM_FIFO_BYPASS_EN: when empty and both sides are ready, the
// beat passes straight through combinationally without being stored.
module stream_fifo_buf
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       valid_in,
  input  logic [DATA_WIDTH-1:0]      data_in,
  output logic                       ready_out,
  output logic                       valid_out,
  output logic [DATA_WIDTH-1:0]      data_out,
  input  logic                       ready_in,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [LW-1:0] level_q, level_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] rd_data;
  logic full, empty, push, pop, bypass;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  assign ready_out = ~full & ~flush;

`ifdef STREAM_FIFO_BYPASS_EN
  assign bypass = empty & valid_in & ready_in & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed beat is consumed downstream in the same cycle, so it is neither
  // stored nor popped.
  assign push = valid_in & ready_out & ~bypass;
  assign pop  = ~empty & ready_in & ~flush;

  always_comb begin
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  stream_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  always_comb begin
    valid_out = ~empty;
    data_out  = empty ? '0 : rd_data;
    if (bypass) begin
      valid_out = 1'b1;
      data_out  = data_in;
    end
  end

  assign level       = level_q;
  assign almost_full = (level_q >= LW'(AFULL_LEVEL));

endmodule
